distribute_1xn_hs: RTL and testbench
====================================

Name: distribute_1xn_hs

Overview:
- Parametrised one-to-N distribution node with a valid/ready handshake on every side and per-output buffering.
- It is the generalisation of the 1x2 sequential distribute node: any number of outputs, an arbitrary multicast bitmask, backpressure, and FIFO depth per branch.
- It sits in the distribution tree between an upstream node/buffer and N downstream nodes/PEs.
- A beat is delivered to every selected output atomically (all-or-nothing).

Parameters:
- DATA_WIDTH, 32, width of one data beat.
- NUM_PORT, 4, number of output branches (>=2).
- FIFO_DEPTH, 2, entries per output FIFO (power of 2, >=2).
- CNT_WIDTH, $clog2(FIFO_DEPTH)+1, occupancy counter width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_en  in  1  node enable; low blocks acceptance only.
- i_valid  in  1  input beat valid.
- o_ready  out  1  node can accept the current beat.
- i_data_bus  in  DATA_WIDTH  input beat.
- i_cmd  in  NUM_PORT  destination mask; bit j selects output j; 0 = discard.
- o_valid  out  NUM_PORT  per-output valid.
- i_ready  in  NUM_PORT  per-output downstream ready.
- o_data_bus  out  NUM_PORT*DATA_WIDTH  output j at [j*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (rst=0, asynchronous): all FIFOs are emptied (pointers and counts = 0). Outputs are o_valid=0, o_data_bus=0, o_ready=0. Release is sampled on clk.
- Per output j: circular FIFO of FIFO_DEPTH entries with rd/wr pointers that wrap modulo FIFO_DEPTH, plus an occupancy count.
  - full[j] = (count==FIFO_DEPTH); empty[j] = (count==0).
- o_ready = i_en & rst & AND over j of (~i_cmd[j] | ~full[j]).
  - Combinational in i_en, i_cmd and registered full only.
  - Never depends on i_ready, so there is no ready-to-ready combinational path.
- Accept: fire = i_valid & o_ready at the rising edge.
  - On fire, i_data_bus is written into every FIFO j with i_cmd[j]=1, on the same edge.
  - Outputs not selected are untouched.
- Discard: i_cmd=0 with i_valid=1 gives o_ready=i_en and the beat is consumed with no write.
- Output j:
  - o_valid[j] = ~empty[j].
  - Data slice = head entry when non-empty, else all zeros (dummy data).
  - Pop on o_valid[j] & i_ready[j].
- Latency: a beat accepted at edge k is visible on the selected outputs after edge k (1 cycle).
- Full FIFO with simultaneous pop: o_ready stays 0 that cycle (no pass-through). The freed slot is usable from the next cycle.
- Non-full FIFO with simultaneous push and pop: count is unchanged and both pointers advance.
- Ordering: each output delivers beats in acceptance order. There is no ordering guarantee across outputs.
- i_en=0: o_ready=0 and no writes; outputs keep draining normally.
- Holding rules:
  - i_cmd and i_data_bus must be held while i_valid=1 & o_ready=0.
  - The upstream may drop i_valid without firing.
- Reset mid-operation: all buffered beats are lost immediately, and o_valid falls asynchronously.
- X on i_cmd or i_data_bus while i_valid=0 must not corrupt state.

Test Plan (DATA_WIDTH=32, NUM_PORT=4, FIFO_DEPTH=2):
1. Reset: rst=0 with i_valid=1, i_cmd=4'b1111 -> o_valid=4'b0000, o_data_bus=128'h0, o_ready=0; no writes after release until a new fire.
2. Unicast: i_ready=4'b1111, i_cmd=4'b0100, data 32'hAAAAAAAA fires at edge k -> after k, o_valid=4'b0100 and slice2=32'hAAAAAAAA, other slices 0. Popped at k+1, o_valid=0 after k+1.
3. Broadcast with backpressure: i_cmd=4'b1111, i_ready=4'b0111, beats A/B/C each offered.
   - A and B fire; o_ready drops once port3 holds 2 entries, so C is stalled.
   - Ports 0-2 have received A,B only (atomicity).
   - Raise i_ready[3]: port3 pops A, C fires the next cycle, and every port outputs A,B,C in order.
4. Discard and enable: i_cmd=4'b0000, i_valid=1 -> o_ready=1, no o_valid change. Then i_en=0 with i_cmd=4'b0011 -> o_ready=0, and previously buffered beats still drain on i_ready.
5. Pointer wrap: port0 only, 5 beats 32'h1..32'h5 with i_ready[0] toggling 1,0,1,... -> port0 delivers 1..5 in order, count never exceeds 2, o_ready=0 exactly in the cycles where port0 is full.
6. Reset mid-operation: ports 1 and 2 each holding 2 beats, pulse rst low between edges -> o_valid=0 immediately. After release, a fresh 32'hBBBBBBBB to i_cmd=4'b0010 appears alone on slice1.

Source files
------------

// File: rtl/distribute_1xn_hs.sv
// distribute_1xn_hs: one-to-N distribution node. Each accepted input beat is
// copied atomically into the FIFO of every output selected by i_cmd; each
// output then drains its FIFO independently under its own valid/ready.
//
// Handshake (every side): a transfer happens on the rising clock edge where
// valid and ready are both high. Valid never waits for ready. The producer
// holds data (and i_cmd on the input side) stable while valid is high and
// ready is low. The upstream may drop i_valid without a transfer.
// o_ready is a function of i_en, i_cmd and registered occupancy only. It
// never looks at i_ready, so no ready-to-ready combinational path exists.
module distribute_1xn_hs #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORT   = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_en,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [DATA_WIDTH-1:0]            i_data_bus,
  input  logic [NUM_PORT-1:0]              i_cmd,
  output logic [NUM_PORT-1:0]              o_valid,
  input  logic [NUM_PORT-1:0]              i_ready,
  output logic [NUM_PORT*DATA_WIDTH-1:0]   o_data_bus
);

  // Pointer width; FIFO_DEPTH is a power of two, so pointers wrap naturally.
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(FIFO_DEPTH);

  logic [NUM_PORT-1:0] full;
  logic [NUM_PORT-1:0] empty;
  logic [NUM_PORT-1:0] push;
  logic [NUM_PORT-1:0] pop;
  logic                fire;
  logic                dest_ok;

  // Acceptance: every selected destination must have a free slot. A full FIFO
  // that pops this cycle still blocks acceptance; the slot frees next cycle.
  always_comb begin
    dest_ok = 1'b1;
    for (int j = 0; j < NUM_PORT; j++) begin
      if (i_cmd[j] && full[j]) dest_ok = 1'b0;
    end
    o_ready = i_en & rst & dest_ok;
  end

  // A beat is consumed on fire; with i_cmd == 0 it is discarded (no writes).
  // Gating by fire keeps unknown i_cmd/i_data_bus harmless while i_valid is low.
  always_comb begin
    fire = i_valid & o_ready;
    push = fire ? i_cmd : '0;
    pop  = ~empty & i_ready;
  end

  for (genvar j = 0; j < NUM_PORT; j++) begin : g_port
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    assign full[j]  = (cnt_q == FULL_CNT);
    assign empty[j] = (cnt_q == '0);

    // Next pointer/count: push and pop may coincide on a non-full FIFO, in
    // which case both pointers move and the count is unchanged.
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push[j]) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop[j])  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push[j], pop[j]})
        2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
        2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    // Pointer/count registers; reset empties the FIFO at once, so o_valid
    // drops asynchronously with rst.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
      end
    end

    // Storage write; contents need no reset because reads are masked by empty.
    always_ff @(posedge clk) begin
      if (push[j]) mem_q[wr_ptr_q] <= i_data_bus;
    end

    // Head of FIFO, or zero dummy data when nothing is buffered.
    assign o_valid[j] = ~empty[j];
    assign o_data_bus[j*DATA_WIDTH +: DATA_WIDTH] =
      empty[j] ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_distribute_1xn_hs.sv
// Bench for distribute_1xn_hs (32-bit data, 4 ports, depth 2): a table of
// hand-computed vectors, hand-written corner sequences and a random run, all
// checked against per-port queues that model the node behaviourally.
module tb_distribute_1xn_hs;
  localparam int DW = 32;
  localparam int NP = 4;
  localparam int DEPTH = 2;
  localparam int BW = NP * DW;

  // clock/reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          i_en, i_valid, o_ready;
  logic [DW-1:0] i_data_bus;
  logic [NP-1:0] i_cmd, o_valid, i_ready;
  logic [BW-1:0] o_data_bus;

  distribute_1xn_hs #(.DATA_WIDTH(DW), .NUM_PORT(NP), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_valid(i_valid), .o_ready(o_ready),
    .i_data_bus(i_data_bus), .i_cmd(i_cmd), .o_valid(o_valid),
    .i_ready(i_ready), .o_data_bus(o_data_bus)
  );

  // scoreboard: expected contents per port, and beats actually delivered
  logic [DW-1:0] exp_q [NP][$];
  logic [DW-1:0] got_q [NP][$];
  int total = 0;
  int bad = 0;
  logic f;

  typedef struct {
    logic          en;
    logic          valid;
    logic [NP-1:0] cmd;
    logic [DW-1:0] data;
    logic [NP-1:0] rdy;
    logic          x_ready;
    logic [NP-1:0] x_valid;
    logic [BW-1:0] x_data;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // driver: apply inputs, check at negedge, advance the model across the edge
  task automatic cycle(input logic en, input logic valid, input logic [NP-1:0] cmd,
                       input logic [DW-1:0] data, input logic [NP-1:0] rdy,
                       input bit use_tbl, input logic t_rdy, input logic [NP-1:0] t_val,
                       input logic [BW-1:0] t_data, output logic fired);
    logic          m_rdy;
    logic [NP-1:0] m_val;
    logic [BW-1:0] m_data;
    i_en = en; i_valid = valid; i_cmd = cmd; i_data_bus = data; i_ready = rdy;
    @(negedge clk);
    m_rdy = rst & en;
    m_val = '0;
    m_data = '0;
    for (int j = 0; j < NP; j++) begin
      if (cmd[j] && exp_q[j].size() >= DEPTH) m_rdy = 1'b0;
      if (exp_q[j].size() > 0) begin
        m_val[j] = 1'b1;
        m_data[j*DW +: DW] = exp_q[j][0];
      end
    end
    if (use_tbl) begin
      chk("tbl_ready", BW'(o_ready), BW'(t_rdy));
      chk("tbl_valid", BW'(o_valid), BW'(t_val));
      chk("tbl_data", o_data_bus, t_data);
    end else begin
      chk("ready", BW'(o_ready), BW'(m_rdy));
      chk("valid", BW'(o_valid), BW'(m_val));
      chk("data", o_data_bus, m_data);
    end
    for (int j = 0; j < NP; j++)
      if (o_valid[j] && rdy[j]) got_q[j].push_back(o_data_bus[j*DW +: DW]);
    fired = valid & m_rdy;
    for (int j = 0; j < NP; j++)
      if (m_val[j] && rdy[j]) void'(exp_q[j].pop_front());
    for (int j = 0; j < NP; j++)
      if (fired && cmd[j]) exp_q[j].push_back(data);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic en, input logic valid, input logic [NP-1:0] cmd,
                      input logic [DW-1:0] data, input logic [NP-1:0] rdy, output logic fired);
    cycle(en, valid, cmd, data, rdy, 1'b0, 1'b0, '0, '0, fired);
  endtask

  task automatic clear_got();
    for (int j = 0; j < NP; j++) got_q[j].delete();
  endtask

  task automatic drain();
    logic fd;
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, '0, '0, '1, fd);
  endtask

  initial begin
    logic [DW-1:0] seq_abc [3];
    int idx;
    int cyc;
    logic hold;
    logic rv;
    logic [NP-1:0] rc;
    logic [DW-1:0] rd;

    tbl[0] = '{1'b1, 1'b1, 4'b0100, 32'hAAAAAAAA, 4'b1111, 1'b1, 4'b0000, 128'h0};
    tbl[1] = '{1'b1, 1'b0, 4'b0000, 32'h0, 4'b1111, 1'b1, 4'b0100,
               128'h00000000_AAAAAAAA_00000000_00000000};
    tbl[2] = '{1'b1, 1'b0, 4'b0000, 32'h0, 4'b1111, 1'b1, 4'b0000, 128'h0};
    tbl[3] = '{1'b1, 1'b1, 4'b0000, 32'h12345678, 4'b1111, 1'b1, 4'b0000, 128'h0};
    tbl[4] = '{1'b1, 1'b0, 4'b0000, 32'h0, 4'b1111, 1'b1, 4'b0000, 128'h0};
    tbl[5] = '{1'b1, 1'b1, 4'b0011, 32'h11111111, 4'b0000, 1'b1, 4'b0000, 128'h0};
    tbl[6] = '{1'b0, 1'b1, 4'b0011, 32'h22222222, 4'b0000, 1'b0, 4'b0011,
               128'h00000000_00000000_11111111_11111111};
    tbl[7] = '{1'b0, 1'b1, 4'b0011, 32'h22222222, 4'b0011, 1'b0, 4'b0011,
               128'h00000000_00000000_11111111_11111111};
    tbl[8] = '{1'b0, 1'b0, 4'b0000, 32'h0, 4'b0011, 1'b0, 4'b0000, 128'h0};

    // reset held while a broadcast beat is offered
    rst = 1'b0; i_en = 1'b1; i_valid = 1'b1; i_cmd = 4'b1111;
    i_data_bus = 32'hDEADBEEF; i_ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", BW'(o_valid), '0);
    chk("rst_data", o_data_bus, '0);
    chk("rst_ready", BW'(o_ready), '0);
    @(posedge clk); #1;
    i_valid = 1'b0;
    rst = 1'b1;
    step(1'b1, 1'b0, 4'b1111, 32'hDEADBEEF, '0, f);
    step(1'b1, 1'b0, '0, '0, '0, f);

    // table: unicast, discard, enable low with draining
    for (int i = 0; i < 9; i++)
      cycle(tbl[i].en, tbl[i].valid, tbl[i].cmd, tbl[i].data, tbl[i].rdy,
            1'b1, tbl[i].x_ready, tbl[i].x_valid, tbl[i].x_data, f);
    drain();

    // broadcast with backpressure on port 3
    clear_got();
    seq_abc[0] = 32'hA0A0A0A0; seq_abc[1] = 32'hB1B1B1B1; seq_abc[2] = 32'hC2C2C2C2;
    step(1'b1, 1'b1, 4'b1111, seq_abc[0], 4'b0111, f);
    chk("t3_a_fire", BW'(f), BW'(1'b1));
    step(1'b1, 1'b1, 4'b1111, seq_abc[1], 4'b0111, f);
    chk("t3_b_fire", BW'(f), BW'(1'b1));
    step(1'b1, 1'b1, 4'b1111, seq_abc[2], 4'b0111, f);
    chk("t3_c_stall", BW'(f), BW'(1'b0));
    chk("t3_atomic", BW'(got_q[0].size()), BW'(2));
    f = 1'b0;
    for (int k = 0; k < 4 && !f; k++) step(1'b1, 1'b1, 4'b1111, seq_abc[2], 4'b1111, f);
    chk("t3_c_fired", BW'(f), BW'(1'b1));
    drain();
    for (int j = 0; j < NP; j++) begin
      chk($sformatf("t3_cnt%0d", j), BW'(got_q[j].size()), BW'(3));
      for (int k = 0; k < 3 && k < got_q[j].size(); k++)
        chk($sformatf("t3_p%0d_b%0d", j, k), BW'(got_q[j][k]), BW'(seq_abc[k]));
    end

    // pointer wrap on port 0 with toggling ready
    clear_got();
    idx = 0;
    cyc = 0;
    while (idx < 5 && cyc < 40) begin
      step(1'b1, 1'b1, 4'b0001, DW'(idx + 1), {3'b000, (cyc % 2) == 0}, f);
      if (f) idx++;
      cyc++;
    end
    chk("t5_all_fired", BW'(idx), BW'(5));
    drain();
    chk("t5_cnt", BW'(got_q[0].size()), BW'(5));
    for (int k = 0; k < 5 && k < got_q[0].size(); k++)
      chk($sformatf("t5_b%0d", k), BW'(got_q[0][k]), BW'(k + 1));
    chk("t5_others", BW'(got_q[1].size() + got_q[2].size() + got_q[3].size()), '0);

    // reset pulse between edges with ports 1 and 2 full
    step(1'b1, 1'b1, 4'b0110, 32'h60000001, '0, f);
    step(1'b1, 1'b1, 4'b0110, 32'h60000002, '0, f);
    i_valid = 1'b0;
    chk("t6_pre", BW'(o_valid), BW'(4'b0110));
    rst = 1'b0;
    #1;
    chk("t6_valid", BW'(o_valid), '0);
    chk("t6_data", o_data_bus, '0);
    chk("t6_ready", BW'(o_ready), '0);
    for (int j = 0; j < NP; j++) exp_q[j].delete();
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 1'b1, 4'b0010, 32'hBBBBBBBB, '0, f);
    cycle(1'b1, 1'b0, '0, '0, '0, 1'b1, 1'b1, 4'b0010,
          128'h00000000_00000000_BBBBBBBB_00000000, f);
    drain();

    // random traffic against the queue model, holding offered beats
    hold = 1'b0;
    rc = '0;
    rd = '0;
    for (int n = 0; n < 800; n++) begin
      if (hold) begin
        rv = ($urandom_range(0, 7) != 0);
      end else begin
        rc = 4'($urandom_range(0, 15));
        rd = $urandom;
        rv = ($urandom_range(0, 3) != 0);
      end
      step($urandom_range(0, 7) != 0, rv, rc, rd, 4'($urandom_range(0, 15)), f);
      hold = rv & ~f;
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
